// File: rtl/dallanma_ongorucu_gshare.sv
// dallanma_ongorucu_gshare: gshare branch/jump predictor with circular RAS,
// tracks each prediction through decode/execute and reports a correction code.
module dallanma_ongorucu_gshare #(
    parameter int         PS_W         = 18,
    parameter int         SAYAC_ADR_W  = 5,
    parameter int         GHT_W        = 8,
    parameter int         RAS_DERINLIK = 4,
    parameter logic [1:0] SAYAC_ILK    = 2'b01
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ddb_durdur_i,
    input  logic [PS_W:1] ps_i,
    input  logic          buyruk_ctipi_i,
    input  logic          buyruk_jal_tipi_i,
    input  logic          buyruk_jalr_tipi_i,
    input  logic          tahmin_et_i,
    input  logic          ras_pop_i,
    input  logic          ras_push_i,
    input  logic [PS_W:1] imm_i,
    output logic [PS_W:1] ongorulen_ps_o,
    output logic          ongorulen_ps_gecerli_o,
    input  logic [PS_W:1] atlanan_ps_i,
    input  logic          atlanan_ps_gecerli_i,
    output logic [1:0]    hata_duzelt_o,
    output logic [PS_W:1] yrt_ps_o,
    output logic          yrt_buyruk_ctipi_o
);
    localparam int         RW            = $clog2(RAS_DERINLIK);
    localparam logic [RW:0] DOLU         = (RW+1)'(RAS_DERINLIK);
    localparam logic [1:0] SORUN_YOK     = 2'd0;
    localparam logic [1:0] ATLAMALIYDI   = 2'd1;
    localparam logic [1:0] ATLAMAMALIYDI = 2'd2;
    localparam logic [1:0] YANLIS_ATLADI = 2'd3;

    typedef struct packed {
        logic                   valid;
        logic [PS_W:1]          ps;
        logic                   ctipi;
        logic                   jal;
        logic                   jalr;
        logic                   taken;
        logic [PS_W:1]          hedef;
        logic [SAYAC_ADR_W-1:0] idx;
        logic [GHT_W-1:0]       ghr;
        logic [RW-1:0]          ptr;
        logic [RW:0]            cnt;
    } asama_t;

    logic [1:0]             sayac [2**SAYAC_ADR_W];
    logic [PS_W:1]          ras   [RAS_DERINLIK];
    logic [GHT_W-1:0]       ghr;
    logic [RW-1:0]          ras_ptr, ptr_n, yaz_adr;
    logic [RW:0]            ras_cnt, cnt_n;
    asama_t                 cyo, yrt, cyo_n;
    logic [SAYAC_ADR_W-1:0] idx;
    logic                   kosul, kontrol, flush, y_kosul;
    logic [1:0]             sayac_y, sayac_yeni;
    logic [PS_W:1]          don_ps;

    assign idx     = ps_i[SAYAC_ADR_W:1] ^ ghr[SAYAC_ADR_W-1:0];
    assign kosul   = !buyruk_jal_tipi_i && !buyruk_jalr_tipi_i;
    assign don_ps  = ps_i + (buyruk_ctipi_i ? PS_W'(1) : PS_W'(2));
    assign yaz_adr = ras_pop_i ? ras_ptr : ras_ptr + 1'b1;

    assign ongorulen_ps_o         = ras_pop_i ? ras[ras_ptr] : ps_i + imm_i;
    assign ongorulen_ps_gecerli_o = tahmin_et_i && (ras_pop_i ? ras_cnt != '0 :
                                    buyruk_jalr_tipi_i ? 1'b0 :
                                    buyruk_jal_tipi_i ? 1'b1 : sayac[idx][1]);

    // RAS state after the fetch instruction's own push/pop
    always_comb begin
        ptr_n = ras_ptr;
        cnt_n = ras_cnt;
        if (tahmin_et_i && ras_push_i && !ras_pop_i) begin
            ptr_n = ras_ptr + 1'b1;
            cnt_n = (ras_cnt == DOLU) ? ras_cnt : ras_cnt + 1'b1;
        end else if (tahmin_et_i && ras_pop_i && !ras_push_i && ras_cnt != '0) begin
            ptr_n = ras_ptr - 1'b1;
            cnt_n = ras_cnt - 1'b1;
        end
    end

    always_comb begin
        cyo_n       = '0;
        cyo_n.valid = tahmin_et_i && !flush;
        cyo_n.ps    = ps_i;
        cyo_n.ctipi = buyruk_ctipi_i;
        cyo_n.jal   = buyruk_jal_tipi_i;
        cyo_n.jalr  = buyruk_jalr_tipi_i;
        cyo_n.taken = ongorulen_ps_gecerli_o;
        cyo_n.hedef = ongorulen_ps_o;
        cyo_n.idx   = idx;
        cyo_n.ghr   = ghr;
        cyo_n.ptr   = ptr_n;
        cyo_n.cnt   = cnt_n;
    end

    assign kontrol       = yrt.valid && !ddb_durdur_i;
    assign y_kosul       = !yrt.jal && !yrt.jalr;
    assign hata_duzelt_o = !kontrol ? SORUN_YOK :
                           (yrt.taken && atlanan_ps_gecerli_i) ?
                               (yrt.hedef == atlanan_ps_i ? SORUN_YOK : YANLIS_ATLADI) :
                           yrt.taken ? ATLAMAMALIYDI :
                           atlanan_ps_gecerli_i ? ATLAMALIYDI : SORUN_YOK;
    assign flush         = hata_duzelt_o != SORUN_YOK;
    assign sayac_y       = sayac[yrt.idx];
    assign sayac_yeni    = atlanan_ps_gecerli_i ? (sayac_y == 2'b11 ? sayac_y : sayac_y + 2'b01)
                                                : (sayac_y == 2'b00 ? sayac_y : sayac_y - 2'b01);
    assign yrt_ps_o           = yrt.ps;
    assign yrt_buyruk_ctipi_o = yrt.ctipi;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 2**SAYAC_ADR_W; i++) sayac[i] <= SAYAC_ILK;
            for (int i = 0; i < RAS_DERINLIK; i++) ras[i] <= '0;
            ghr     <= '0;
            ras_ptr <= '0;
            ras_cnt <= '0;
            cyo     <= '0;
            yrt     <= '0;
        end else if (!ddb_durdur_i) begin
            if (kontrol && y_kosul) sayac[yrt.idx] <= sayac_yeni;
            // repair from the mispredicting instruction's checkpoint beats any fetch update
            if (flush) begin
                ghr     <= y_kosul ? {yrt.ghr[GHT_W-2:0], atlanan_ps_gecerli_i} : yrt.ghr;
                ras_ptr <= yrt.ptr;
                ras_cnt <= yrt.cnt;
            end else if (tahmin_et_i) begin
                if (kosul) ghr <= {ghr[GHT_W-2:0], ongorulen_ps_gecerli_o};
                if (ras_push_i) ras[yaz_adr] <= don_ps;
                ras_ptr <= ptr_n;
                ras_cnt <= cnt_n;
            end
            cyo       <= cyo_n;
            yrt       <= cyo;
            yrt.valid <= cyo.valid && !flush;
        end
    end
endmodule

// File: tb/tb_dallanma_ongorucu_gshare.sv
// tb_dallanma_ongorucu_gshare: directed checks of prediction, training,
// history/RAS repair and stall behaviour of the gshare predictor.
module tb_dallanma_ongorucu_gshare;
    localparam int PS_W = 18;
    localparam logic [1:0] SORUN_YOK = 2'd0, ATLAMALIYDI = 2'd1, ATLAMAMALIYDI = 2'd2;

    logic            clk_i = 1'b0, rst_i = 1'b1, ddb_durdur_i = 1'b0;
    logic [PS_W:1]   ps_i = '0, imm_i = '0, atlanan_ps_i = '0;
    logic            buyruk_ctipi_i = 1'b0, buyruk_jal_tipi_i = 1'b0, buyruk_jalr_tipi_i = 1'b0;
    logic            tahmin_et_i = 1'b0, ras_pop_i = 1'b0, ras_push_i = 1'b0, atlanan_ps_gecerli_i = 1'b0;
    logic [PS_W:1]   ongorulen_ps_o, yrt_ps_o;
    logic            ongorulen_ps_gecerli_o, yrt_buyruk_ctipi_o;
    logic [1:0]      hata_duzelt_o;
    int              checks = 0, errors = 0;

    dallanma_ongorucu_gshare dut (
        .clk_i(clk_i), .rst_i(rst_i), .ddb_durdur_i(ddb_durdur_i), .ps_i(ps_i),
        .buyruk_ctipi_i(buyruk_ctipi_i), .buyruk_jal_tipi_i(buyruk_jal_tipi_i),
        .buyruk_jalr_tipi_i(buyruk_jalr_tipi_i), .tahmin_et_i(tahmin_et_i),
        .ras_pop_i(ras_pop_i), .ras_push_i(ras_push_i), .imm_i(imm_i),
        .ongorulen_ps_o(ongorulen_ps_o), .ongorulen_ps_gecerli_o(ongorulen_ps_gecerli_o),
        .atlanan_ps_i(atlanan_ps_i), .atlanan_ps_gecerli_i(atlanan_ps_gecerli_i),
        .hata_duzelt_o(hata_duzelt_o), .yrt_ps_o(yrt_ps_o), .yrt_buyruk_ctipi_o(yrt_buyruk_ctipi_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic getir(input logic [PS_W:1] ps, input logic [PS_W:1] imm,
                         input logic jal, input logic jalr, input logic pop, input logic push);
        ps_i = ps; imm_i = imm; buyruk_jal_tipi_i = jal; buyruk_jalr_tipi_i = jalr;
        ras_pop_i = pop; ras_push_i = push; tahmin_et_i = 1'b1;
    endtask

    task automatic bos();
        tahmin_et_i = 1'b0; buyruk_jal_tipi_i = 1'b0; buyruk_jalr_tipi_i = 1'b0;
        ras_pop_i = 1'b0; ras_push_i = 1'b0;
    endtask

    // one instruction alone in the pipe: predict, carry two stages, resolve
    task automatic tek(input string tag, input logic [PS_W:1] ps, input logic [PS_W:1] imm,
                       input logic jal, input logic jalr, input logic pop, input logic push,
                       input logic ptk, input logic [PS_W:1] ptgt,
                       input logic rtk, input logic [PS_W:1] rtgt, input logic [1:0] eh);
        getir(ps, imm, jal, jalr, pop, push);
        #1;
        chk({tag, " taken"}, ongorulen_ps_gecerli_o, ptk);
        if (ptk || !pop) chk({tag, " target"}, ongorulen_ps_o, ptgt);
        step();
        bos();
        step();
        chk({tag, " yrt_ps"}, yrt_ps_o, ps);
        atlanan_ps_gecerli_i = rtk; atlanan_ps_i = rtgt;
        #1;
        chk({tag, " hata"}, hata_duzelt_o, eh);
        step();
        atlanan_ps_gecerli_i = 1'b0;
    endtask

    initial begin
        #12 rst_i = 1'b0;
        #1;
        chk("rst hata", hata_duzelt_o, SORUN_YOK);
        chk("rst yrt_ps", yrt_ps_o, 0);
        chk("rst ctipi", yrt_buyruk_ctipi_o, 0);
        chk("rst ghr", dut.ghr, 0);
        chk("rst sayac", dut.sayac[0], 2'b01);
        chk("rst ras_cnt", dut.ras_cnt, 0);
        step();

        tek("t1", 18'h40, 18'h10, 0, 0, 0, 0, 0, 18'h50, 1, 18'h50, ATLAMALIYDI);
        chk("t1 sayac", dut.sayac[0], 2'b10);
        chk("t1 ghr", dut.ghr, 8'h01);
        chk("t1 hata after", hata_duzelt_o, SORUN_YOK);
        tek("t2a", 18'h41, 18'h10, 0, 0, 0, 0, 1, 18'h51, 1, 18'h51, SORUN_YOK);
        chk("t2a sayac", dut.sayac[0], 2'b11);
        chk("t2a ghr", dut.ghr, 8'h03);
        tek("t2b", 18'h43, 18'h10, 0, 0, 0, 0, 1, 18'h53, 1, 18'h53, SORUN_YOK);
        chk("t2b sayac", dut.sayac[0], 2'b11);
        chk("t2b ghr", dut.ghr, 8'h07);

        // A (idx 0, taken) then B (idx 0xF, not taken); A resolves not taken
        getir(18'h47, 18'h10, 0, 0, 0, 0);
        #1;
        chk("t3 A taken", ongorulen_ps_gecerli_o, 1);
        step();
        getir(18'h60, 18'h10, 0, 0, 0, 0);
        #1;
        chk("t3 B taken", ongorulen_ps_gecerli_o, 0);
        step();
        bos();
        chk("t3 A yrt", yrt_ps_o, 18'h47);
        atlanan_ps_gecerli_i = 1'b0;
        #1;
        chk("t3 hata", hata_duzelt_o, ATLAMAMALIYDI);
        step();
        chk("t3 ghr", dut.ghr, 8'h0E);
        chk("t3 sayac A", dut.sayac[0], 2'b10);
        atlanan_ps_gecerli_i = 1'b1; atlanan_ps_i = 18'h70;
        #1;
        chk("t3 B flushed", hata_duzelt_o, SORUN_YOK);
        step();
        atlanan_ps_gecerli_i = 1'b0;
        chk("t3 sayac B", dut.sayac[15], 2'b01);

        for (int i = 0; i < 5; i++)
            tek("t4 push", 18'h100 + 18'(i), 18'h20, 1, 0, 0, 1, 1, 18'h120 + 18'(i),
                1, 18'h120 + 18'(i), SORUN_YOK);
        chk("t4 ras_cnt", dut.ras_cnt, 4);
        chk("t4 ghr", dut.ghr, 8'h0E);
        for (int i = 0; i < 4; i++)
            tek("t4 pop", 18'h300, 18'h0, 0, 1, 1, 0, 1, 18'h106 - 18'(i),
                1, 18'h106 - 18'(i), SORUN_YOK);
        tek("t4 pop5", 18'h300, 18'h0, 0, 1, 1, 0, 0, 18'h0, 0, 18'h0, SORUN_YOK);
        chk("t4 ras_cnt end", dut.ras_cnt, 0);
        chk("t4 ras_ptr end", dut.ras_ptr, 1);

        // mispredicting branch (idx 0xE) held in execute by a stall
        getir(18'h40, 18'h10, 0, 0, 0, 0);
        #1;
        chk("t5 taken", ongorulen_ps_gecerli_o, 0);
        step();
        bos();
        step();
        ddb_durdur_i = 1'b1; atlanan_ps_gecerli_i = 1'b1; atlanan_ps_i = 18'h50;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5 stall hata", hata_duzelt_o, SORUN_YOK);
            step();
            chk("t5 stall sayac", dut.sayac[14], 2'b01);
            chk("t5 stall ghr", dut.ghr, 8'h1C);
        end
        ddb_durdur_i = 1'b0;
        #1;
        chk("t5 release hata", hata_duzelt_o, ATLAMALIYDI);
        step();
        chk("t5 sayac", dut.sayac[14], 2'b10);
        chk("t5 ghr", dut.ghr, 8'h1D);
        chk("t5 once", hata_duzelt_o, SORUN_YOK);
        atlanan_ps_gecerli_i = 1'b0;
        step();
        chk("t5 no second", dut.sayac[14], 2'b10);

        // branch X, call C1, then X mispredicts while call C2 is fetched
        getir(18'h40, 18'h10, 0, 0, 0, 0);
        step();
        getir(18'h200, 18'h10, 1, 0, 0, 1);
        #1;
        chk("t6 C1 taken", ongorulen_ps_gecerli_o, 1);
        step();
        chk("t6 C1 ptr", dut.ras_ptr, 2);
        getir(18'h300, 18'h10, 1, 0, 0, 1);
        atlanan_ps_gecerli_i = 1'b1; atlanan_ps_i = 18'h50;
        #1;
        chk("t6 hata", hata_duzelt_o, ATLAMALIYDI);
        step();
        bos();
        chk("t6 ras_ptr", dut.ras_ptr, 1);
        chk("t6 ras_cnt", dut.ras_cnt, 0);
        chk("t6 ras3 kept", dut.ras[3], 18'h104);
        chk("t6 ghr", dut.ghr, 8'h3B);
        #1;
        chk("t6 C1 flushed", hata_duzelt_o, SORUN_YOK);
        step();
        atlanan_ps_gecerli_i = 1'b0;

        rst_i = 1'b1;
        #1;
        chk("rst2 sayac", dut.sayac[0], 2'b01);
        chk("rst2 ghr", dut.ghr, 0);
        chk("rst2 ras_cnt", dut.ras_cnt, 0);
        chk("rst2 yrt_ps", yrt_ps_o, 0);
        rst_i = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dallanma_ongorucu_gshare.md
Name: dallanma_ongorucu_gshare

Overview:
Parametrised gshare branch/jump predictor for the fetch stage (getir), with a circular return address stack (RAS).
- Predicts at fetch, tracks each prediction through decode (coz) and execute (yurut), checks it at execute and emits the 2-bit hata_duzelt code.
- Generalises table size, history length and RAS depth.
- Adds per-branch history checkpoints, RAS pointer repair on mispredict, and stall-safe updates.

Parameters:
PS_W, 18, program counter width; PC ports are [PS_W:1] (halfword address).
SAYAC_ADR_W, 5, log2 of 2-bit counter table entries.
GHT_W, 8, global history register length; must be >= SAYAC_ADR_W.
RAS_DERINLIK, 4, RAS entries; power of two.
SAYAC_ILK, 2'b01, counter value after reset.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
ddb_durdur_i  in  1  pipeline stall; freezes all stage registers and updates
ps_i  in  PS_W  fetch PC
buyruk_ctipi_i  in  1  fetch instruction is compressed
buyruk_jal_tipi_i  in  1  fetch instruction is JAL
buyruk_jalr_tipi_i  in  1  fetch instruction is JALR
tahmin_et_i  in  1  fetch instruction is branch/jump; predict it
ras_pop_i  in  1  return-type jump
ras_push_i  in  1  call-type jump
imm_i  in  PS_W  branch/JAL offset, halfword units
ongorulen_ps_o  out  PS_W  predicted target
ongorulen_ps_gecerli_o  out  1  predicted taken
atlanan_ps_i  in  PS_W  resolved target from execute
atlanan_ps_gecerli_i  in  1  execute resolved taken
hata_duzelt_o  out  2  SORUN_YOK / ATLAMALIYDI / ATLAMAMALIYDI / YANLIS_ATLADI; encodings as in tanimlamalar.vh
yrt_ps_o  out  PS_W  PC of the instruction in execute
yrt_buyruk_ctipi_o  out  1  execute instruction is compressed

Behaviour:
- Reset, asynchronous:
  - all counters = SAYAC_ILK; GHR = 0
  - RAS contents, top pointer and count = 0
  - all stage valid bits = 0
  - hata_duzelt_o = SORUN_YOK; yrt_ps_o = 0; yrt_buyruk_ctipi_o = 0
  - reset mid-operation discards all in-flight predictions.
- Index: idx = ps_i[SAYAC_ADR_W:1] XOR GHR[SAYAC_ADR_W-1:0].
- Prediction, combinational, same cycle:
  - ras_pop_i with RAS count > 0: target = RAS top, taken = 1.
  - ras_pop_i with RAS empty: taken = 0.
  - JALR without pop: taken = 0.
  - JAL: taken = 1, target = ps_i + imm_i.
  - Conditional branch: taken = counter[idx][1], target = ps_i + imm_i.
  - Arithmetic is modulo 2^PS_W.
- Fetch-side updates occur when tahmin_et_i && !ddb_durdur_i && no flush this cycle.
  - GHR: for conditional branches only, GHR <= {GHR[GHT_W-2:0], predicted taken}.
  - RAS push only: pointer+1, write ps_i + (ctipi ? 1 : 2), count = min(count+1, RAS_DERINLIK). When full, the oldest entry is overwritten.
  - RAS pop only: pointer-1, count-1; no change if count = 0.
  - RAS push and pop together: overwrite top with the return address; pointer and count unchanged.
- Pipeline: two register stages, CYO then YURUT, advancing only when !ddb_durdur_i. Each stage carries:
  - valid, PC, ctipi, jal/jalr flags, predicted taken, predicted target, idx
  - GHR value before this instruction's update (checkpoint)
  - RAS pointer and count after this instruction's RAS operation.
- Check at execute: only when YURUT valid && !ddb_durdur_i; otherwise hata_duzelt_o = SORUN_YOK.
  - resolved taken, predicted taken, targets equal -> SORUN_YOK
  - resolved not taken, predicted not taken -> SORUN_YOK
  - predicted taken, resolved not taken -> ATLAMAMALIYDI
  - predicted not taken, resolved taken -> ATLAMALIYDI
  - both taken, targets differ -> YANLIS_ATLADI
- Training, same check cycle, conditional branches only: counter[carried idx] moves one step toward the resolved direction, saturating at 0 and 3. Counters are written exactly once per branch, even if the stall rises afterwards.
- Mispredict (hata_duzelt_o != SORUN_YOK):
  - GHR <= {checkpoint[GHT_W-2:0], resolved taken}, conditional branches only; jumps restore the checkpoint unchanged.
  - RAS pointer and count restored from the carried values; entry contents are not repaired.
  - CYO and YURUT valid bits cleared at the next edge.
  - A fetch-side update in the same cycle is suppressed; repair wins.
- yrt_ps_o and yrt_buyruk_ctipi_o mirror the YURUT stage registers.

Test Plan:
- Reset, then a branch at ps=0x40 with imm=0x10 -> ongorulen_ps_gecerli_o=0, ongorulen_ps_o=0x50; after 2 cycles with atlanan_ps_gecerli_i=1 and atlanan_ps_i=0x50 -> ATLAMALIYDI, counter becomes 2'b10.
- Same branch resolved taken 3 times with history held constant -> counter saturates at 3; 4th prediction taken; a further taken resolution leaves it at 3.
- Predict branch A taken, then branch B; A resolves not taken -> ATLAMAMALIYDI, GHR = {checkpoint_A[GHT_W-2:0], 0}, B's valid bit cleared, B causes no counter update.
- 5 pushes at ps=0x100..0x104 (ctipi=0), RAS_DERINLIK=4 -> pops return 0x106, 0x105, 0x104, 0x103; 5th pop gives ongorulen_ps_gecerli_o=0.
- Hold ddb_durdur_i=1 for 3 cycles with a mispredicting branch in YURUT -> hata_duzelt_o=SORUN_YOK and no counter change while stalled; one ATLAMALIYDI and one update after release.
- Call predicted, then an older branch mispredicts in the same cycle as a new push -> push suppressed; RAS pointer equals the value carried by the mispredicting branch.
